vgachargen_map_arbiter: RTL and testbench
=========================================

# vgachargen_map_arbiter

Shares the single-port, synchronous-read character/colour map RAM between two requesters: the scanout fetch engine (read-only, hard real-time) and the host bus side (read/write, valid/ready). Scan requests always win and are never delayed. A host transaction is held in a one-entry buffer until the port has a free slot. The block sits between the APB register front-end, the pixel pipeline and the map RAM.

## Interface
Parameters:
- WAIT_MAX, 255: number of blocked host-pending cycles after which starvation is flagged; WAIT_W = $clog2(WAIT_MAX+1).

Widths come from package constants: A = CH_MAP_ADDR_WIDTH (12), D = CH_MAP_DATA_WIDTH (8).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low.
- scan_req_i  in  1  scan read request; served in the same cycle
- scan_addr_i  in  A  scan read address
- scan_rvalid_o  out  1  scan read data valid
- scan_rdata_o  out  D  scan read data; wired to mem_rdata_i
- host_valid_i  in  1  host request valid
- host_ready_o  out  1  host request accepted when valid && ready
- host_we_i  in  1  1 = write, 0 = read
- host_addr_i  in  A  host address
- host_wdata_i  in  D  host write data
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  D  host read data; wired to mem_rdata_i
- mem_en_o  out  1  RAM enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  A  RAM address
- mem_wdata_o  out  D  RAM write data
- mem_rdata_i  in  D  RAM read data, valid 1 cycle after a read
- host_starve_clr_i  in  1  clears host_starve_o
- host_starve_o  out  1  sticky starvation flag

## Operation
Memory port mux (combinational):
- scan_req_i=1: mem_en=1, mem_we=0, mem_addr=scan_addr_i.
- Else, in state PEND: the port is driven from the holding register (en=1, we=hold.we, addr, wdata).
- Else: mem_en=0, mem_we=0. Address and write data are driven from the holding register (don't-care).

FSM states are ARB_IDLE, ARB_PEND and ARB_RESP.
- IDLE: host_ready_o=1. On valid && ready, capture {we, addr, wdata} into the holding register and go to PEND.
- PEND: host_ready_o=0.
  - If scan_req_i=1, stay in PEND.
  - Otherwise, issue the held transaction. A write returns to IDLE; a read goes to RESP.
- RESP: host_ready_o=0 and host_rvalid_o=1 for exactly this cycle. Always return to IDLE.
- scan_rvalid_o is scan_req_i delayed one cycle.
- scan_rvalid_o and host_rvalid_o are never high together, because only one requester is issued per cycle.
- Scan requests are legal in every state, including RESP. A scan issued in RESP returns its data in the following cycle.
- Host fields only need to be stable in the cycle the request is accepted.

## Timing
- While rstn_i=0:
  - state=IDLE, holding register and wait counter cleared.
  - host_ready_o=0, host_rvalid_o=0, scan_rvalid_o=0, mem_en_o=0, mem_we_o=0, host_starve_o=0.
  - Scan requests are ignored during reset.
- Reset mid-operation drops any pending host transaction without issuing it.
- Host accepted at T with no scan at T+1: the RAM access occurs at T+1.
  - Read: host_rvalid_o at T+2; the next accept is possible at T+3.
  - Write: host_ready_o=1 again at T+2.
- Each blocking scan cycle in PEND adds one cycle of host latency.
- Scan latency is fixed at 1 cycle. Host latency is unbounded; the scan fetch pattern guarantees slots in practice.

## Configuration
Macro: VGACHARGEN_ARB_STARVE_DET_EN.
- Defined:
  - A saturating WAIT_W counter is cleared on entry to PEND and increments on each PEND cycle with scan_req_i=1.
  - When the count reaches WAIT_MAX, host_starve_o sets on the next edge and stays set.
  - host_starve_clr_i clears the flag. If set and clear occur together, set wins.
- Undefined: no counter is built, host_starve_o is tied to 0, and host_starve_clr_i is ignored. The ports stay present in both cases.

## Structure
- In vgachargen_pkg:
  - arb_state_e {ARB_IDLE, ARB_PEND, ARB_RESP}.
  - map_req_t {we, addr[CH_MAP_ADDR_WIDTH], wdata[CH_MAP_DATA_WIDTH]}.
- Sub-module vgachargen_arb_wait_cnt (saturating counter plus sticky flag), instantiated only under the macro.

## Test plan
- Reset: rstn_i=0 for 3 cycles with host_valid_i=1 and scan_req_i=1 -> ready, en and both rvalids stay 0; host_ready_o=1 on the first cycle after release.
- Idle write: accept at T with we=1, addr 12'h0A5, wdata 8'h41, no scan -> at T+1 en=1, we=1, addr 0A5, wdata 41; host_ready_o=1 at T+2.
- Blocked read: host read of 12'h010 accepted at T; scan_req_i high T+1..T+3 at 12'h100..102 -> scan_rvalid_o at T+2..T+4; host read issued at T+4; host_rvalid_o at T+5 with the RAM contents of 12'h010.
- Simultaneous: scan_req_i and host_valid_i both at T -> scan served at T, host accepted at T, host issued at T+1.
- Starvation (macro on, WAIT_MAX=255):
  - 254 blocked cycles -> host_starve_o=0.
  - 255 blocked cycles -> host_starve_o=1 and held after the scan stops; a clr pulse returns it to 0.
  - Macro off -> host_starve_o stays 0 throughout.
- Reset in PEND: a write is pending and blocked, then rstn_i=0 for 1 cycle -> no RAM write occurs; host_ready_o=1 after release.

Source files
------------

// File: rtl/vgachargen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_pkg
// Purpose  : Shared types and widths for the character/colour map arbiter.
//            Holds the map RAM geometry, the arbiter state encoding and the
//            buffered host request record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vgachargen_pkg;

  localparam int CH_MAP_ADDR_WIDTH = 12;
  localparam int CH_MAP_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PEND = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                         we;
    logic [CH_MAP_ADDR_WIDTH-1:0] addr;
    logic [CH_MAP_DATA_WIDTH-1:0] wdata;
  } map_req_t;

endpackage
`default_nettype wire

// File: rtl/vgachargen_arb_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_arb_wait_cnt
// Purpose  : Saturating count of scan-blocked cycles for a pending host
//            request, plus a sticky starvation flag.
// Ports    : clk_i, rstn_i     clock / synchronous active-low reset
//            cnt_clr_i         restart the count (host request accepted)
//            cnt_inc_i         one more blocked cycle
//            pend_i            a host request is currently pending
//            flag_clr_i        clear the sticky flag (set has priority)
//            flag_o            sticky starvation flag
// Revision : 1.0 - initial release
// ============================================================================
module vgachargen_arb_wait_cnt
  import vgachargen_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = $clog2(WAIT_MAX + 1)
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic cnt_clr_i,
  input  logic cnt_inc_i,
  input  logic pend_i,
  input  logic flag_clr_i,
  output logic flag_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic              at_max;

  assign at_max = (cnt_q == WAIT_W'(WAIT_MAX));

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_inc_i && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Setting is qualified by pend_i so a saturated count left over from an
    // old request cannot re-raise the flag after software clears it.
    if (pend_i && at_max) begin
      flag_d = 1'b1;
    end else if (flag_clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule
`default_nettype wire

// File: rtl/vgachargen_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_map_arbiter
// Purpose  : Shares the single-port synchronous-read map RAM between the
//            scanout fetch engine (always wins, 1-cycle latency) and the host
//            bus (valid/ready, one-entry holding buffer).
// Ports    : clk_i, rstn_i                         clock / sync active-low reset
//            scan_req_i, scan_addr_i               scan read request
//            scan_rvalid_o, scan_rdata_o           scan read return
//            host_valid_i/ready_o/we_i/addr_i/wdata_i  host request
//            host_rvalid_o, host_rdata_o           host read return
//            mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i  RAM port
//            host_starve_clr_i, host_starve_o      starvation flag
// Config   : VGACHARGEN_ARB_STARVE_DET_EN builds the starvation detector;
//            when undefined host_starve_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module vgachargen_map_arbiter
  import vgachargen_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = $clog2(WAIT_MAX + 1)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         scan_req_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] scan_addr_i,
  output logic                         scan_rvalid_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] scan_rdata_o,
  input  logic                         host_valid_i,
  output logic                         host_ready_o,
  input  logic                         host_we_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] host_addr_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] host_wdata_i,
  output logic                         host_rvalid_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] host_rdata_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                         host_starve_clr_i,
  output logic                         host_starve_o
);

  arb_state_e state_q, state_d;
  map_req_t   hold_q, hold_d;
  logic       scan_rvalid_q, scan_rvalid_d;
  logic       issue_host;
  logic       accept;

  // Next-state and host handshake
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    host_ready_o  = 1'b0;
    host_rvalid_o = 1'b0;
    issue_host    = 1'b0;
    accept        = 1'b0;
    scan_rvalid_d = scan_req_i;
    unique case (state_q)
      ARB_IDLE: begin
        host_ready_o = 1'b1;
        if (host_valid_i) begin
          accept = 1'b1;
          hold_d = '{we: host_we_i, addr: host_addr_i, wdata: host_wdata_i};
          state_d = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (!scan_req_i) begin
          issue_host = 1'b1;
          state_d    = hold_q.we ? ARB_IDLE : ARB_RESP;
        end
      end
      ARB_RESP: begin
        host_rvalid_o = 1'b1;
        state_d       = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // Reset is synchronous, so the registered state may still be stale during
    // the reset cycle; force every externally visible strobe low meanwhile.
    if (!rstn_i) begin
      host_ready_o  = 1'b0;
      host_rvalid_o = 1'b0;
      issue_host    = 1'b0;
      accept        = 1'b0;
    end
  end

  // RAM port mux: scan has absolute priority
  always_comb begin
    mem_en_o    = rstn_i & (scan_req_i | issue_host);
    mem_we_o    = rstn_i & ~scan_req_i & issue_host & hold_q.we;
    mem_addr_o  = scan_req_i ? scan_addr_i : hold_q.addr;
    mem_wdata_o = hold_q.wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ARB_IDLE;
      hold_q        <= '0;
      scan_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      scan_rvalid_q <= scan_rvalid_d;
    end
  end

  assign scan_rvalid_o = rstn_i & scan_rvalid_q;
  assign scan_rdata_o  = mem_rdata_i;
  assign host_rdata_o  = mem_rdata_i;

`ifdef VGACHARGEN_ARB_STARVE_DET_EN
  logic starve_flag;

  vgachargen_arb_wait_cnt #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .cnt_clr_i  (accept),
    .cnt_inc_i  ((state_q == ARB_PEND) && scan_req_i),
    .pend_i     (state_q == ARB_PEND),
    .flag_clr_i (host_starve_clr_i),
    .flag_o     (starve_flag)
  );

  assign host_starve_o = rstn_i & starve_flag;
`else
  logic              unused_starve_clr;
  logic              unused_accept;
  logic [WAIT_W-1:0] unused_wait_max;

  assign unused_starve_clr = host_starve_clr_i;
  assign unused_accept     = accept;
  assign unused_wait_max   = WAIT_W'(WAIT_MAX);
  assign host_starve_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vgachargen_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vgachargen_map_arbiter
// Purpose  : Directed self-checking bench for vgachargen_map_arbiter with a
//            behavioural synchronous-read map RAM. RAM preload is
//            ram[a] = a[7:0] ^ 8'h5A.
// Config   : VGACHARGEN_ARB_STARVE_DET_EN selects the expected starvation
//            behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vgachargen_map_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        scan_req_i;
  logic [11:0] scan_addr_i;
  logic        scan_rvalid_o;
  logic [7:0]  scan_rdata_o;
  logic        host_valid_i;
  logic        host_ready_o;
  logic        host_we_i;
  logic [11:0] host_addr_i;
  logic [7:0]  host_wdata_i;
  logic        host_rvalid_o;
  logic [7:0]  host_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        host_starve_clr_i;
  logic        host_starve_o;

  int checks = 0;
  int errors = 0;

`ifdef VGACHARGEN_ARB_STARVE_DET_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  vgachargen_map_arbiter #(.WAIT_MAX(255)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .scan_req_i        (scan_req_i),
    .scan_addr_i       (scan_addr_i),
    .scan_rvalid_o     (scan_rvalid_o),
    .scan_rdata_o      (scan_rdata_o),
    .host_valid_i      (host_valid_i),
    .host_ready_o      (host_ready_o),
    .host_we_i         (host_we_i),
    .host_addr_i       (host_addr_i),
    .host_wdata_i      (host_wdata_i),
    .host_rvalid_o     (host_rvalid_o),
    .host_rdata_o      (host_rdata_o),
    .mem_en_o          (mem_en_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_rdata_i       (mem_rdata_i),
    .host_starve_clr_i (host_starve_clr_i),
    .host_starve_o     (host_starve_o)
  );

  // Behavioural single-port synchronous-read RAM
  logic [7:0] ram [0:4095];
  int         wr_cnt = 0;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = i[7:0] ^ 8'h5A;
  end

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        ram[mem_addr_o] <= mem_wdata_o;
        wr_cnt          <= wr_cnt + 1;
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; host_valid_i = 1'b1; scan_req_i = 1'b1; scan_addr_i = 12'h003;
    host_we_i = 1'b1; host_addr_i = 12'h001; host_wdata_i = 8'h11; host_starve_clr_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (host_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready cyc %0d got %b exp 0", c, host_ready_o); end
      checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL rst_mem_en cyc %0d got %b exp 0", c, mem_en_o); end
      checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_mem_we cyc %0d got %b exp 0", c, mem_we_o); end
      checks++; if (host_rvalid_o !== 1'b0 || scan_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid cyc %0d got h%b s%b exp 0", c, host_rvalid_o, scan_rvalid_o); end
      checks++; if (host_starve_o !== 1'b0) begin errors++; $display("FAIL rst_starve cyc %0d got %b exp 0", c, host_starve_o); end
      next_cycle();
    end
    rstn_i = 1'b1; host_valid_i = 1'b0; scan_req_i = 1'b0;
    #1;
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", host_ready_o); end
    checks++; if (scan_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_release_srv got %b exp 0", scan_rvalid_o); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rst_no_write got %0d exp 0", wr_cnt); end
    next_cycle();
  endtask

  task automatic test_idle_write();
    host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h0A5; host_wdata_i = 8'h41;
    #1;
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL wr_accept_ready got %b exp 1", host_ready_o); end
    checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL wr_T_en got %b exp 0", mem_en_o); end
    next_cycle();
    host_valid_i = 1'b0; host_addr_i = 12'hFFF; host_wdata_i = 8'h00;
    #1;
    checks++; if ({mem_en_o, mem_we_o} !== 2'b11) begin errors++; $display("FAIL wr_T1_en_we got %b exp 11", {mem_en_o, mem_we_o}); end
    checks++; if (mem_addr_o !== 12'h0A5) begin errors++; $display("FAIL wr_T1_addr got %h exp 0a5", mem_addr_o); end
    checks++; if (mem_wdata_o !== 8'h41) begin errors++; $display("FAIL wr_T1_wdata got %h exp 41", mem_wdata_o); end
    checks++; if (host_ready_o !== 1'b0) begin errors++; $display("FAIL wr_T1_ready got %b exp 0", host_ready_o); end
    next_cycle();
    #1;
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL wr_T2_ready got %b exp 1", host_ready_o); end
    checks++; if (ram[12'h0A5] !== 8'h41) begin errors++; $display("FAIL wr_ram got %h exp 41", ram[12'h0A5]); end
    checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL wr_T2_en got %b exp 0", mem_en_o); end
  endtask

  task automatic test_back_to_back();
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h0A5;
    next_cycle();
    host_valid_i = 1'b0;
    #1;
    checks++; if ({mem_en_o, mem_we_o} !== 2'b10 || mem_addr_o !== 12'h0A5) begin errors++; $display("FAIL b2b_rd_issue got en%b we%b a%h exp en1 we0 a0a5", mem_en_o, mem_we_o, mem_addr_o); end
    next_cycle();
    #1;
    checks++; if (host_rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid got %b exp 1", host_rvalid_o); end
    checks++; if (host_rdata_o !== 8'h41) begin errors++; $display("FAIL b2b_rdata got %h exp 41", host_rdata_o); end
    checks++; if (host_ready_o !== 1'b0 || scan_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_resp_rdy_srv got %b%b exp 00", host_ready_o, scan_rvalid_o); end
    next_cycle();
    host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h0A6; host_wdata_i = 8'h99;
    #1;
    checks++; if (host_ready_o !== 1'b1 || host_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_T3_ready got rdy%b rv%b exp rdy1 rv0", host_ready_o, host_rvalid_o); end
    next_cycle();
    host_valid_i = 1'b0;
    #1;
    checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 12'h0A6 || mem_wdata_o !== 8'h99) begin errors++; $display("FAIL b2b_wr_issue got we%b a%h d%h exp we1 a0a6 d99", mem_we_o, mem_addr_o, mem_wdata_o); end
    next_cycle();
  endtask

  task automatic test_blocked_read();
    logic [7:0] exp_scan [0:2];
    exp_scan[0] = 8'h5A; exp_scan[1] = 8'h5B; exp_scan[2] = 8'h58;
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h010;
    #1;
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL blk_accept_ready got %b exp 1", host_ready_o); end
    next_cycle();
    host_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      scan_req_i = 1'b1; scan_addr_i = 12'h100 + 12'(k);
      #1;
      checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h100 + 12'(k)) begin errors++; $display("FAIL blk_scan_port k%0d got en%b we%b a%h", k, mem_en_o, mem_we_o, mem_addr_o); end
      checks++; if (host_ready_o !== 1'b0 || host_rvalid_o !== 1'b0) begin errors++; $display("FAIL blk_host_idle k%0d got rdy%b rv%b exp 00", k, host_ready_o, host_rvalid_o); end
      if (k > 0) begin
        checks++; if (scan_rvalid_o !== 1'b1 || scan_rdata_o !== exp_scan[k-1]) begin errors++; $display("FAIL blk_scan_ret k%0d got v%b d%h exp v1 d%h", k, scan_rvalid_o, scan_rdata_o, exp_scan[k-1]); end
      end
      next_cycle();
    end
    scan_req_i = 1'b0;
    #1;
    checks++; if (scan_rvalid_o !== 1'b1 || scan_rdata_o !== exp_scan[2]) begin errors++; $display("FAIL blk_scan_ret_last got v%b d%h exp v1 d%h", scan_rvalid_o, scan_rdata_o, exp_scan[2]); end
    checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h010) begin errors++; $display("FAIL blk_host_issue got en%b we%b a%h exp en1 we0 a010", mem_en_o, mem_we_o, mem_addr_o); end
    next_cycle();
    #1;
    checks++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== 8'h4A) begin errors++; $display("FAIL blk_host_ret got v%b d%h exp v1 d4a", host_rvalid_o, host_rdata_o); end
    checks++; if (scan_rvalid_o !== 1'b0) begin errors++; $display("FAIL blk_srv_excl got %b exp 0", scan_rvalid_o); end
    next_cycle();
    #1;
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL blk_ready_back got %b exp 1", host_ready_o); end
  endtask

  task automatic test_simultaneous();
    scan_req_i = 1'b1; scan_addr_i = 12'h200;
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h020;
    #1;
    checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 12'h200) begin errors++; $display("FAIL sim_scan_port got en%b a%h exp en1 a200", mem_en_o, mem_addr_o); end
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL sim_ready got %b exp 1", host_ready_o); end
    next_cycle();
    scan_req_i = 1'b0; host_valid_i = 1'b0;
    #1;
    checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h020) begin errors++; $display("FAIL sim_host_issue got en%b we%b a%h exp en1 we0 a020", mem_en_o, mem_we_o, mem_addr_o); end
    checks++; if (scan_rvalid_o !== 1'b1 || scan_rdata_o !== 8'h5A) begin errors++; $display("FAIL sim_scan_ret got v%b d%h exp v1 d5a", scan_rvalid_o, scan_rdata_o); end
    next_cycle();
    #1;
    checks++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== 8'h7A) begin errors++; $display("FAIL sim_host_ret got v%b d%h exp v1 d7a", host_rvalid_o, host_rdata_o); end
    next_cycle();
  endtask

  task automatic test_starvation(input int n_blocked, input bit exp_flag);
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h030;
    next_cycle();
    host_valid_i = 1'b0; scan_req_i = 1'b1; scan_addr_i = 12'h300;
    for (int k = 0; k < n_blocked; k++) next_cycle();
    scan_req_i = 1'b0;
    #1;
    checks++; if (host_starve_o !== 1'b0) begin errors++; $display("FAIL stv_pre_n%0d got %b exp 0", n_blocked, host_starve_o); end
    checks++; if (mem_addr_o !== 12'h030 || mem_en_o !== 1'b1) begin errors++; $display("FAIL stv_issue_n%0d got en%b a%h exp en1 a030", n_blocked, mem_en_o, mem_addr_o); end
    next_cycle();
    #1;
    checks++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== 8'h6A) begin errors++; $display("FAIL stv_ret_n%0d got v%b d%h exp v1 d6a", n_blocked, host_rvalid_o, host_rdata_o); end
    checks++; if (host_starve_o !== exp_flag) begin errors++; $display("FAIL stv_flag_n%0d got %b exp %b", n_blocked, host_starve_o, exp_flag); end
    for (int k = 0; k < 3; k++) next_cycle();
    #1;
    checks++; if (host_starve_o !== exp_flag) begin errors++; $display("FAIL stv_hold_n%0d got %b exp %b", n_blocked, host_starve_o, exp_flag); end
    host_starve_clr_i = 1'b1;
    next_cycle();
    host_starve_clr_i = 1'b0;
    #1;
    checks++; if (host_starve_o !== 1'b0) begin errors++; $display("FAIL stv_clr_n%0d got %b exp 0", n_blocked, host_starve_o); end
    next_cycle();
    #1;
    checks++; if (host_starve_o !== 1'b0) begin errors++; $display("FAIL stv_clr_stays_n%0d got %b exp 0", n_blocked, host_starve_o); end
  endtask

  task automatic test_reset_pend();
    int wr0;
    wr0 = wr_cnt;
    host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h0F0; host_wdata_i = 8'hEE;
    next_cycle();
    host_valid_i = 1'b0; scan_req_i = 1'b1; scan_addr_i = 12'h111;
    #1;
    checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== 12'h111) begin errors++; $display("FAIL rp_blocked got we%b a%h exp we0 a111", mem_we_o, mem_addr_o); end
    next_cycle();
    rstn_i = 1'b0;
    #1;
    checks++; if (mem_en_o !== 1'b0 || host_ready_o !== 1'b0) begin errors++; $display("FAIL rp_in_reset got en%b rdy%b exp 00", mem_en_o, host_ready_o); end
    next_cycle();
    rstn_i = 1'b1; scan_req_i = 1'b0;
    #1;
    checks++; if (host_ready_o !== 1'b1 || mem_en_o !== 1'b0) begin errors++; $display("FAIL rp_release got rdy%b en%b exp rdy1 en0", host_ready_o, mem_en_o); end
    next_cycle();
    #1;
    checks++; if (wr_cnt !== wr0 || ram[12'h0F0] !== 8'hAA) begin errors++; $display("FAIL rp_no_write got wr%0d d%h exp wr%0d daa", wr_cnt, ram[12'h0F0], wr0); end
    checks++; if (mem_en_o !== 1'b0 || host_rvalid_o !== 1'b0) begin errors++; $display("FAIL rp_quiet got en%b rv%b exp 00", mem_en_o, host_rvalid_o); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_back_to_back();
    test_blocked_read();
    test_simultaneous();
    test_starvation(254, 1'b0);
    test_starvation(255, STARVE_EN);
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
